// File: rtl/tm_xin_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tm_xin_loader : streams host words into the classifier XIN memory, then     |
// | runs the classifier and holds result_valid until acked.   Rev 1.0           |
// +----------------------------------------------------------------------------+
module tm_xin_loader #(
  parameter int                  LA_CHUNKS = 49,
  parameter int                  INT_SIZE  = 32,
  parameter logic [INT_SIZE-1:0] FILTER    = 32'hFFFFFFFF,
  parameter int                  AW        = $clog2(LA_CHUNKS)
) (
  input  logic                clk,
  input  logic                rst_flag,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [INT_SIZE-1:0] s_data,
  input  logic                s_last,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [INT_SIZE-1:0] mem_wdata,
  output logic                tm_rst,
  input  logic                tm_full_done,
  output logic                result_valid,
  input  logic                result_ack,
  output logic                err_len
);

  localparam logic [AW-1:0] LAST_IDX = AW'(LA_CHUNKS - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [INT_SIZE-1:0] wdata_q, wdata_d;
  logic                ready_q, tmrst_q, rvalid_q;

  logic                hs;
  logic                last_word;

  assign hs        = s_valid & ready_q;
  assign last_word = (cnt_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_LOAD: begin
        if (hs) begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = last_word ? (s_data & FILTER) : s_data;
          // A new sample clears the error unless this very word sets it again.
          if (cnt_q == '0) begin
            err_d = 1'b0;
          end
          if (last_word) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            if (!s_last) begin
              err_d = 1'b1;
            end
          end else if (s_last) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      ST_RUN: begin
        if (tm_full_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (result_ack) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake and classifier-control outputs are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (!rst_flag) begin
      state_q  <= ST_LOAD;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b1;
      tmrst_q  <= 1'b1;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ready_q  <= (state_d == ST_LOAD);
      tmrst_q  <= (state_d == ST_LOAD);
      rvalid_q <= (state_d == ST_DONE);
    end
  end

  assign s_ready      = ready_q;
  assign tm_rst       = tmrst_q;
  assign result_valid = rvalid_q;
  assign err_len      = err_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_tm_xin_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tm_xin_loader : scoreboard bench with a sample-level reference model.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_tm_xin_loader;

  localparam int          L    = 49;
  localparam logic [31:0] FILT = 32'h0000FFFF;

  logic        clk = 1'b0;
  logic        rst_flag = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        tm_rst;
  logic        tm_full_done = 1'b0;
  logic        result_valid;
  logic        result_ack = 1'b0;
  logic        err_len;

  tm_xin_loader #(
    .LA_CHUNKS(L),
    .INT_SIZE (32),
    .FILTER   (FILT)
  ) dut (
    .clk         (clk),
    .rst_flag    (rst_flag),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .tm_rst      (tm_rst),
    .tm_full_done(tm_full_done),
    .result_valid(result_valid),
    .result_ack  (result_ack),
    .err_len     (err_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          at;
  } wr_t;
  wr_t exp_q[$];

  // Reference model: phase 0 = loading, 1 = classifier running, 2 = result held.
  int m_phase = 0;
  int m_cnt   = 0;
  bit m_err   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr_unexpected: got write addr %0d data %0h expected none (cycle %0d)",
                 mem_addr, mem_wdata, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", mem_wdata, e.data);
        chk("wr_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic step(input bit v, input bit last, input logic [31:0] d,
                      input bit fd, input bit ack, input bit rstn);
    wr_t e;
    s_valid      = v;
    s_last       = last;
    s_data       = d;
    tm_full_done = fd;
    result_ack   = ack;
    rst_flag     = rstn;
    if (!rstn) begin
      m_phase = 0;
      m_cnt   = 0;
      m_err   = 1'b0;
    end else if (m_phase == 0) begin
      if (v) begin
        e.addr = m_cnt;
        e.data = (m_cnt == L - 1) ? (d & FILT) : d;
        e.at   = cyc + 1;
        exp_q.push_back(e);
        if (m_cnt == 0) m_err = 1'b0;
        if ((m_cnt == L - 1 && !last) || (m_cnt < L - 1 && last)) m_err = 1'b1;
        if (m_cnt == L - 1) begin
          m_phase = 1;
          m_cnt   = 0;
        end else if (last) begin
          m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end else if (m_phase == 1) begin
      if (fd) m_phase = 2;
    end else begin
      if (ack) m_phase = 0;
    end
    @(posedge clk);
    #1;
    chk("s_ready", 32'(s_ready), 32'(m_phase == 0));
    chk("tm_rst", 32'(tm_rst), 32'(m_phase == 0));
    chk("result_valid", 32'(result_valid), 32'(m_phase == 2));
    chk("err_len", 32'(err_len), 32'(m_err));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, $urandom, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps with
  // stray full_done/ack that must be ignored while loading.
  task automatic send_sample(input int n, input int last_at, input int mode, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (mode == 1) begin
        idle();
      end else if (mode == 2) begin
        repeat ($urandom_range(0, 2))
          step(1'b0, 1'($urandom_range(0, 1)), $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      end
      step(1'b1, (i == last_at), rnd ? $urandom : 32'(i), 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic finish_run(input int run_cycles, input int hold_cycles, input bit both);
    repeat (run_cycles) step(1'b0, 1'b0, 32'd0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, both, 1'b1);
    repeat (hold_cycles) step(1'b0, 1'b0, 32'd0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    // Reset values
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk_reset_vals();
    idle();
    chk_reset_vals();

    // Nominal load, then completion with a long hold before ack
    send_sample(L, L - 1, 0, 1'b0);
    finish_run(3, 10, 1'b0);

    // Throttled source
    send_sample(L, L - 1, 1, 1'b0);
    finish_run(2, 4, 1'b1);

    // Early s_last, then a clean sample that must restart at addr 0
    send_sample(11, 10, 0, 1'b1);
    send_sample(L, L - 1, 0, 1'b1);
    finish_run(1, 2, 1'b0);

    // Full sample without s_last still runs
    send_sample(L, -1, 0, 1'b1);
    idle();
    finish_run(2, 1, 1'b0);

    // Reset during RUN
    send_sample(L, L - 1, 0, 1'b1);
    idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk_reset_vals();
    idle();

    // Reset in LOAD after 20 words
    send_sample(20, -1, 0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk_reset_vals();
    send_sample(L, L - 1, 0, 1'b1);
    finish_run(2, 2, 1'b0);

    // Randomized samples
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 3) == 0)
        send_sample($urandom_range(1, L - 1), $urandom_range(0, L - 2), 2, 1'b1);
      send_sample(L, ($urandom_range(0, 4) == 0) ? -1 : L - 1, 2, 1'b1);
      finish_run($urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    idle();
    idle();
    chk("wr_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
